// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings for the stream multiplexer.
package mux_pkg;
   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant, searching last+1, last+2, ... mod NCH.
module rr_arbiter #(
   parameter int NCH = 3,
   parameter int IW  = 2
) (
   input  logic [NCH-1:0] req_i,
   input  logic [IW-1:0]  last_i,
   output logic [NCH-1:0] gnt_o,
   output logic [IW-1:0]  idx_o
);
   logic [IW-1:0] c;
   // Walk from the farthest candidate inward so the nearest requester wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      c     = '0;
      for (int k = NCH; k >= 1; k--) begin
         c = IW'((int'(last_i) + k) % NCH);
         if (req_i[c]) begin
            gnt_o    = '0;
            gnt_o[c] = 1'b1;
            idx_o    = c;
         end
      end
   end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NCH-to-1 stream mux with a one-beat output register,
// fixed-select or round-robin arbitration.
module stream_mux_rr
   import mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCH   = 3,
   parameter int MODE  = MODE_FIXED
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NCH*WIDTH-1:0]     in_data,
   input  logic [NCH-1:0]           in_valid,
   output logic [NCH-1:0]           in_ready,
   input  logic [$clog2(NCH)-1:0]   sel,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(NCH)-1:0]   out_ch,
   output logic                     out_valid,
   input  logic                     out_ready
);
   localparam int IW = $clog2(NCH);
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [IW-1:0]    out_ch_q, out_ch_d, last_q, last_d, gidx;
   logic             out_valid_q, out_valid_d, slot_free, cap;
   logic [NCH-1:0]   gnt;
   logic [WIDTH-1:0] ch_data [NCH];

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
   end

   if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
         .req_i  (in_valid),
         .last_i (last_q),
         .gnt_o  (gnt),
         .idx_o  (gidx)
      );
   end else begin : g_fix
      // Out-of-range select grants nobody.
      assign gidx = sel;
      assign gnt  = (int'(sel) < NCH) ? (NCH'(1) << sel) : '0;
   end

   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = (slot_free && rst_n) ? gnt : '0;
   assign cap       = |(in_ready & in_valid);

   always_comb begin
      out_valid_d = cap || (out_valid_q && !out_ready);
      out_data_d  = cap ? ch_data[gidx] : out_data_q;
      out_ch_d    = cap ? gidx : out_ch_q;
      last_d      = cap ? gidx : last_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         last_q      <= IW'(NCH - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         last_q      <= last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
endmodule
